// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the load/store unit:
//   - lsu_state_e : sequencer states
//   - lsu_size_e  : access size encoding as seen on request_size
//   - misaligned(): alignment / legality check for a request
// ----------------------------------------------------------------------------
package lsu_pkg;

  localparam int unsigned LSU_ADDRESS_WIDTH = 32;
  localparam int unsigned LSU_WORD_WIDTH    = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_MERGE   = 3'd2,
    ST_STORE   = 3'd3,
    ST_RESPOND = 3'd4
  } lsu_state_e;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } lsu_size_e;

  // A request is rejected when the size is illegal or the address is not
  // naturally aligned for the access size. Bytes are always aligned.
  function automatic logic misaligned(input lsu_size_e size, input logic [1:0] addr_low);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_low[0];
      SIZE_WORD: bad = (addr_low != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lane_aligner.sv
// ----------------------------------------------------------------------------
// lane_aligner
// Purely combinational little-endian lane logic for a 32-bit word memory.
// Ports:
//   word_i        in  32  memory word (load source / old word for merge)
//   store_data_i  in  32  right-justified store data
//   addr_low_i    in  2   byte offset within the word
//   size_i        in  2   access size (lsu_size_e encoding)
//   unsigned_i    in  1   zero-extend loads instead of sign-extending
//   load_result_o out 32  selected lane, extended to 32 bits
//   merged_o      out 32  word_i with the addressed lane replaced
// ----------------------------------------------------------------------------
module lane_aligner
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] store_data_i,
  input  logic [1:0]  addr_low_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] load_result_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  lsu_size_e   size_s;

  assign size_s = lsu_size_e'(size_i);

  // Lane selection: byte lane = addr[1:0], halfword lane = addr[1].
  always_comb begin
    byte_s = 8'h00;
    case (addr_low_i)
      2'b00:   byte_s = word_i[7:0];
      2'b01:   byte_s = word_i[15:8];
      2'b10:   byte_s = word_i[23:16];
      2'b11:   byte_s = word_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_low_i[1]) begin
      half_s = word_i[31:16];
    end else begin
      half_s = word_i[15:0];
    end
  end

  // Load extension of the selected lane.
  always_comb begin
    load_result_o = 32'h0000_0000;
    case (size_s)
      SIZE_BYTE: begin
        if (unsigned_i) begin
          load_result_o = {24'h00_0000, byte_s};
        end else begin
          load_result_o = {{24{byte_s[7]}}, byte_s};
        end
      end
      SIZE_HALF: begin
        if (unsigned_i) begin
          load_result_o = {16'h0000, half_s};
        end else begin
          load_result_o = {{16{half_s[15]}}, half_s};
        end
      end
      SIZE_WORD: load_result_o = word_i;
      default:   load_result_o = 32'h0000_0000;
    endcase
  end

  // Store merge: only the addressed lane takes the low bits of store data.
  always_comb begin
    merged_o = word_i;
    case (size_s)
      SIZE_BYTE: begin
        case (addr_low_i)
          2'b00:   merged_o[7:0]   = store_data_i[7:0];
          2'b01:   merged_o[15:8]  = store_data_i[7:0];
          2'b10:   merged_o[23:16] = store_data_i[7:0];
          2'b11:   merged_o[31:24] = store_data_i[7:0];
          default: merged_o        = word_i;
        endcase
      end
      SIZE_HALF: begin
        if (addr_low_i[1]) begin
          merged_o[31:16] = store_data_i[15:0];
        end else begin
          merged_o[15:0] = store_data_i[15:0];
        end
      end
      SIZE_WORD: merged_o = store_data_i;
      default:   merged_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Sequencer between the execute stage and a word-only data memory. Accepts
// one request at a time, performs byte/halfword/word loads and stores (sub-word
// stores as read-modify-write) and returns a single-cycle response.
// Ports:
//   clock, reset_n               clock and synchronous active-low reset
//   request_valid/ready          request handshake (ready only in IDLE)
//   request_write/size/unsigned  access kind, size and load extension
//   request_address              byte address
//   request_write_data           right-justified store data
//   response_valid               one-cycle completion pulse
//   response_data                extended load data (0 for stores/errors)
//   response_misaligned          request rejected, memory untouched
//   memory_address               word-aligned address to the memory
//   memory_write_enable          write strobe, high only in STORE
//   memory_write_data            full or merged word to write
//   memory_read_data             combinational read data from the memory
// ----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned address_width = 32,
  parameter int unsigned word_width    = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     request_valid,
  output logic                     request_ready,
  input  logic                     request_write,
  input  logic [1:0]               request_size,
  input  logic                     request_unsigned,
  input  logic [address_width-1:0] request_address,
  input  logic [word_width-1:0]    request_write_data,
  output logic                     response_valid,
  output logic [word_width-1:0]    response_data,
  output logic                     response_misaligned,
  output logic [address_width-1:0] memory_address,
  output logic                     memory_write_enable,
  output logic [word_width-1:0]    memory_write_data,
  input  logic [word_width-1:0]    memory_read_data
);

  lsu_state_e               state_q;
  lsu_size_e                size_q;
  logic                     unsigned_q;
  logic [1:0]               addr_low_q;
  logic [word_width-1:0]    store_word_q;
  logic [word_width-1:0]    response_data_q;
  logic                     response_misaligned_q;
  logic [address_width-1:0] memory_address_q;

  logic [31:0] load_result_s;
  logic [31:0] merged_s;
  lsu_size_e   request_size_s;
  logic        request_error_s;

  assign request_size_s  = lsu_size_e'(request_size);
  assign request_error_s = misaligned(request_size_s, request_address[1:0]);

  lane_aligner u_lane_aligner (
    .word_i        (memory_read_data),
    .store_data_i  (store_word_q),
    .addr_low_i    (addr_low_q),
    .size_i        (size_q),
    .unsigned_i    (unsigned_q),
    .load_result_o (load_result_s),
    .merged_o      (merged_s)
  );

  // Sequencer FSM and all datapath registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q               <= ST_IDLE;
      size_q                <= SIZE_BYTE;
      unsigned_q            <= 1'b0;
      addr_low_q            <= 2'b00;
      store_word_q          <= '0;
      response_data_q       <= '0;
      response_misaligned_q <= 1'b0;
      memory_address_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (request_valid) begin
            size_q                <= request_size_s;
            unsigned_q            <= request_unsigned;
            addr_low_q            <= request_address[1:0];
            // Holds the raw store data; MERGE overwrites it for sub-word stores.
            store_word_q          <= request_write_data;
            memory_address_q      <= {request_address[address_width-1:2], 2'b00};
            response_data_q       <= '0;
            response_misaligned_q <= request_error_s;
            if (request_error_s) begin
              state_q <= ST_RESPOND;
            end else if (!request_write) begin
              state_q <= ST_LOAD;
            end else if (request_size_s == SIZE_WORD) begin
              state_q <= ST_STORE;
            end else begin
              state_q <= ST_MERGE;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          response_data_q <= load_result_s;
          state_q         <= ST_RESPOND;
        end
        ST_MERGE: begin
          store_word_q <= merged_s;
          state_q      <= ST_STORE;
        end
        ST_STORE: begin
          state_q <= ST_RESPOND;
        end
        ST_RESPOND: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake strobes decode the state register; reset_n gates them so an
  // aborted operation can never write or respond.
  assign request_ready       = reset_n && (state_q == ST_IDLE);
  assign response_valid      = reset_n && (state_q == ST_RESPOND);
  assign memory_write_enable = reset_n && (state_q == ST_STORE);

  assign response_data       = response_data_q;
  assign response_misaligned = response_misaligned_q;
  assign memory_address      = memory_address_q;
  assign memory_write_data   = store_word_q;

endmodule
